// File: rtl/mem_copy_pkg.sv
// Shared types and defaults for the byte-wide memory copy engine.
package mem_copy_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned LEN_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Mode fields captured with an accepted start; zero when fill mode is not built.
    typedef struct packed {
        logic       fill;
        logic [7:0] fill_byte;
    } req_t;

endpackage

// File: rtl/mem_copy_if.sv
// Byte-wide single-port memory bus; the copy engine is master, the memory is slave.
interface mem_copy_if
    import mem_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;

    modport master (output read, write, addr, wdata, input rdata);
    modport slave  (input read, write, addr, wdata, output rdata);
endinterface

// File: rtl/mem_copy_ctr.sv
// Source/destination address registers and remaining-byte down-counter for the copy engine.
module mem_copy_ctr #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] src_cur,
    output logic [ADDR_W-1:0] dst_cur,
    output logic              last
);

    logic [LEN_W-1:0] remaining;

    // last is precomputed so it marks the final byte while that byte is being written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_cur   <= '0;
            dst_cur   <= '0;
            remaining <= '0;
            last      <= 1'b0;
        end else if (load) begin
            src_cur   <= src;
            dst_cur   <= dst;
            remaining <= len;
            last      <= (len == LEN_W'(1));
        end else if (step) begin
            src_cur   <= ADDR_W'(src_cur + 1'b1);
            dst_cur   <= ADDR_W'(dst_cur + 1'b1);
            remaining <= LEN_W'(remaining - 1'b1);
            last      <= (remaining == LEN_W'(2));
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Byte-at-a-time block copy initiator on the single-port memory bus.
// Optional MEM_COPY_FILL_EN adds a fill mode writing a constant byte at one cycle per byte.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
`ifdef MEM_COPY_FILL_EN
    input  logic              fill,
    input  logic [7:0]        fill_byte,
`endif
    output logic              busy,
    output logic              done,
    mem_copy_if.master        mem
);

    state_e            state;
    req_t              req_in;
    req_t              req_q;
    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] dst_cur;
    logic              last;
    logic              accept_c;
    logic              step_c;

    always_comb begin
        req_in = '0;
`ifdef MEM_COPY_FILL_EN
        req_in.fill      = fill;
        req_in.fill_byte = fill_byte;
`endif
    end

    assign accept_c = (state == IDLE) && start;
    assign step_c   = (state == WR);

    mem_copy_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept_c),
        .step    (step_c),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .src_cur (src_cur),
        .dst_cur (dst_cur),
        .last    (last)
    );

    // Bus outputs are set on the transition into the state that owns them, so they are pure flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem.read  <= 1'b0;
            mem.write <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        req_q <= req_in;
                        busy  <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (req_in.fill) begin
                            state     <= WR;
                            mem.write <= 1'b1;
                            mem.addr  <= dst;
                            mem.wdata <= req_in.fill_byte;
                        end else begin
                            state    <= RD;
                            mem.read <= 1'b1;
                            mem.addr <= src;
                        end
                    end
                end
                RD: begin
                    state     <= WR;
                    mem.read  <= 1'b0;
                    mem.write <= 1'b1;
                    mem.addr  <= dst_cur;
                    mem.wdata <= mem.rdata;
                end
                WR: begin
                    if (last) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        mem.write <= 1'b0;
                        mem.addr  <= '0;
                        mem.wdata <= '0;
                    end else if (req_q.fill) begin
                        mem.addr <= ADDR_W'(dst_cur + 1'b1);
                    end else begin
                        state     <= RD;
                        mem.write <= 1'b0;
                        mem.read  <= 1'b1;
                        mem.addr  <= ADDR_W'(src_cur + 1'b1);
                        mem.wdata <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
